// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt sources/processor and irq_controller.
// The master side drives sources, mask writes, overrun clear and ack; the
// slave side (the controller) returns the request, id and status registers.
interface irq_controller_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] irq_src;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               ovr_clr;
    logic               irq_ack;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] overrun;

    modport master (
        output irq_src, mask_we, mask_wdata, ovr_clr, irq_ack,
        input  irq_out, irq_id, pending, mask, overrun
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, ovr_clr, irq_ack,
        output irq_out, irq_id, pending, mask, overrun
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: per-source edge detect, pending/overrun latching,
// enable mask, fixed lowest-index priority, req/ack handshake to the CPU and
// a hold-off gap between successive requests.

// Per-source cell: edge detect, pending bit and sticky overrun flag.
module irq_src_cell (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic clr,      // ack of this source this cycle
    input  logic ovr_clr,
    output logic pend,
    output logic ovr
);
    logic src_d;
    logic evt;

    // History resets high so a source held through reset is not an event.
    assign evt = src & ~src_d;

    // Edge history, pending (set beats clear) and overrun (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d <= 1'b1;
            pend  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            src_d <= src;
            pend  <= (pend & ~clr) | evt;
            ovr   <= (ovr & ~ovr_clr) | (evt & pend & ~clr);
        end
    end
endmodule

module irq_controller #(
    parameter int NUM_SRC = 4,
    parameter int HOLDOFF = 4,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input logic             clk,
    input logic             reset,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [ID_W-1:0]    id_q, id_nxt;
    logic               irq_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] ovr;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] req;
    logic               sel_vld;
    logic [ID_W-1:0]    sel_id;
    logic               ack_fire;

    // Ack only counts while a request is actually outstanding.
    assign ack_fire = (state == ASSERT) & bus.irq_ack;
    assign req      = pend & mask_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign clr[i] = ack_fire & (id_q == ID_W'(i));

        irq_src_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .src     (bus.irq_src[i]),
            .clr     (clr[i]),
            .ovr_clr (bus.ovr_clr),
            .pend    (pend[i]),
            .ovr     (ovr[i])
        );
    end

    // Fixed priority: scan high to low so the lowest pending index is kept.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_vld = 1'b1;
                sel_id  = ID_W'(i);
            end
        end
    end

    // Next-state logic; irq_id is latched on entry to ASSERT and held otherwise.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        id_nxt    = id_q;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    id_nxt    = sel_id;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                if (bus.irq_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'(HOLDOFF - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter, id, registered request line and mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            id_q   <= '0;
            irq_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            id_q   <= id_nxt;
            irq_q  <= (state_nxt == ASSERT);
            if (bus.mask_we) mask_q <= bus.mask_wdata;
        end
    end

    assign bus.irq_out = irq_q;
    assign bus.irq_id  = id_q;
    assign bus.pending = pend;
    assign bus.mask    = mask_q;
    assign bus.overrun = ovr;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with default parameters (4 sources,
// hold-off 4). Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_irq_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    irq_controller_if #(.NUM_SRC(4), .ID_W(2)) bus ();

    irq_controller #(.NUM_SRC(4), .HOLDOFF(4), .ID_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        bus.mask_we = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.irq_src = 4'b1111;
        bus.mask_we = 1'b0;
        bus.mask_wdata = 4'b0000;
        bus.ovr_clr = 1'b0;
        bus.irq_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.irq_out, bus.irq_id, bus.pending, bus.mask, bus.overrun} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%b id=%0d pend=%b mask=%b ovr=%b, want all 0",
                     bus.irq_out, bus.irq_id, bus.pending, bus.mask, bus.overrun);
        end
        reset = 1'b0;
        write_mask(4'b1111);
        tick();
        tick();
        checks++;
        if (bus.pending !== 4'b0000 || bus.irq_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_src: got pend=%b out=%b, want 0000/0", bus.pending, bus.irq_out);
        end
        bus.irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        write_mask(4'b0001);
        checks++;
        if (bus.mask !== 4'b0001) begin
            failures++;
            $display("FAIL single_mask: got %b want 0001", bus.mask);
        end
        bus.irq_src = 4'b0001;
        tick(); // edge N
        checks++;
        if (bus.pending !== 4'b0001 || bus.irq_out !== 1'b0) begin
            failures++;
            $display("FAIL single_N: got pend=%b out=%b, want 0001/0", bus.pending, bus.irq_out);
        end
        tick(); // edge N+1
        bus.irq_src = 4'b0000;
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            failures++;
            $display("FAIL single_N1: got out=%b id=%0d, want 1/0", bus.irq_out, bus.irq_id);
        end
        tick();
        bus.irq_ack = 1'b1;
        tick(); // edge M
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.pending !== 4'b0000) begin
            failures++;
            $display("FAIL single_ack: got out=%b pend=%b, want 0/0000", bus.irq_out, bus.pending);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (bus.irq_out !== 1'b0) begin
                failures++;
                $display("FAIL single_no_second: cycle %0d got out=%b want 0", k, bus.irq_out);
            end
        end
    endtask

    task automatic test_priority();
        write_mask(4'b1111);
        bus.irq_src = 4'b1010;
        tick();
        checks++;
        if (bus.pending !== 4'b1010) begin
            failures++;
            $display("FAIL prio_pend: got %b want 1010", bus.pending);
        end
        tick();
        bus.irq_src = 4'b0000;
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd1) begin
            failures++;
            $display("FAIL prio_first: got out=%b id=%0d, want 1/1", bus.irq_out, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        tick(); // edge M
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.pending !== 4'b1000 || bus.irq_id !== 2'd1) begin
            failures++;
            $display("FAIL prio_ack: got out=%b pend=%b id=%0d, want 0/1000/1",
                     bus.irq_out, bus.pending, bus.irq_id);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(); // M+1..M+4
            checks++;
            if (bus.irq_out !== 1'b0) begin
                failures++;
                $display("FAIL prio_holdoff: M+%0d got out=%b want 0", k, bus.irq_out);
            end
        end
        tick(); // M+5
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd3) begin
            failures++;
            $display("FAIL prio_second: got out=%b id=%0d, want 1/3", bus.irq_out, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        repeat (6) tick();
        checks++;
        if (bus.irq_out !== 1'b0 || bus.pending !== 4'b0000) begin
            failures++;
            $display("FAIL prio_drain: got out=%b pend=%b, want 0/0000", bus.irq_out, bus.pending);
        end
    endtask

    task automatic test_masked();
        write_mask(4'b0000);
        bus.irq_src = 4'b0100;
        tick();
        bus.irq_src = 4'b0000;
        repeat (3) tick();
        checks++;
        if (bus.pending !== 4'b0100 || bus.irq_out !== 1'b0) begin
            failures++;
            $display("FAIL masked_hold: got pend=%b out=%b, want 0100/0", bus.pending, bus.irq_out);
        end
        write_mask(4'b0100); // edge K
        checks++;
        if (bus.mask !== 4'b0100 || bus.irq_out !== 1'b0) begin
            failures++;
            $display("FAIL masked_K: got mask=%b out=%b, want 0100/0", bus.mask, bus.irq_out);
        end
        tick(); // K+1
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd2) begin
            failures++;
            $display("FAIL masked_K1: got out=%b id=%0d, want 1/2", bus.irq_out, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_overrun();
        write_mask(4'b0000);
        for (int p = 0; p < 2; p++) begin
            bus.irq_src = 4'b0001;
            tick();
            bus.irq_src = 4'b0000;
            tick();
        end
        checks++;
        if (bus.overrun !== 4'b0001 || bus.pending !== 4'b0001) begin
            failures++;
            $display("FAIL overrun_set: got ovr=%b pend=%b, want 0001/0001", bus.overrun, bus.pending);
        end
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        checks++;
        if (bus.overrun !== 4'b0000 || bus.pending !== 4'b0001) begin
            failures++;
            $display("FAIL overrun_clr: got ovr=%b pend=%b, want 0000/0001", bus.overrun, bus.pending);
        end
    endtask

    // Relies on pending[0] left set by test_overrun.
    task automatic test_ack_collision();
        write_mask(4'b0001);
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            failures++;
            $display("FAIL coll_assert: got out=%b id=%0d, want 1/0", bus.irq_out, bus.irq_id);
        end
        bus.irq_src = 4'b0001;
        bus.irq_ack = 1'b1;
        tick(); // edge M
        bus.irq_src = 4'b0000;
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.pending !== 4'b0001 || bus.overrun !== 4'b0000) begin
            failures++;
            $display("FAIL coll_ack: got out=%b pend=%b ovr=%b, want 0/0001/0000",
                     bus.irq_out, bus.pending, bus.overrun);
        end
        repeat (4) tick();
        checks++;
        if (bus.irq_out !== 1'b0) begin
            failures++;
            $display("FAIL coll_holdoff: got out=%b want 0", bus.irq_out);
        end
        tick(); // M+5
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            failures++;
            $display("FAIL coll_second: got out=%b id=%0d, want 1/0", bus.irq_out, bus.irq_id);
        end
        // Asynchronous reset between clock edges.
        reset = 1'b1;
        #1;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.pending !== 4'b0000 || bus.overrun !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got out=%b pend=%b ovr=%b, want 0/0000/0000",
                     bus.irq_out, bus.pending, bus.overrun);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.irq_out !== 1'b0 || bus.mask !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset: got out=%b mask=%b, want 0/0000", bus.irq_out, bus.mask);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masked();
        test_overrun();
        test_ack_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller sitting between the kernel's interrupt sources (1 s tick generator, capture-done, UART, trigger) and the soft processor's single interrupt input. It edge-detects each source, latches events into pending bits, applies a software-written enable mask, and selects one source by fixed priority. It then drives the processor with a request/acknowledge handshake and enforces a hold-off gap between successive interrupts.

## Interface
- NUM_SRC, 4, number of interrupt sources (2..16)
- HOLDOFF, 4, minimum idle cycles after an ack before the next request (1..255)
- ID_W, max(1, clog2(NUM_SRC)), width of source index
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- irq_src  in  NUM_SRC  level/pulse sources; a rising edge is one event
- mask_we  in  1  write strobe for enable mask
- mask_wdata  in  NUM_SRC  new mask, 1 = enabled
- ovr_clr  in  1  clears all overrun flags
- irq_ack  in  1  processor acknowledge, one-cycle pulse
- irq_out  out  1  interrupt request to processor
- irq_id  out  ID_W  index of the source being serviced
- pending  out  NUM_SRC  pending register
- mask  out  NUM_SRC  current enable mask
- overrun  out  NUM_SRC  sticky per-source lost-event flags

## Operation
- Reset values: irq_out=0, irq_id=0, pending=0, mask=0, overrun=0, state=IDLE, hold-off counter=0, edge-detect history=all ones. A source held high through reset produces no event.
- Edge detect: event[i] = irq_src[i] & ~src_d[i]; src_d registered every cycle. A multi-cycle pulse (e.g. the 2-cycle 1 s tick) is one event.
- Pending: event[i] sets pending[i], whether or not it is masked. An ack clears pending[irq_id]. If a set and a clear hit the same bit in the same cycle, set wins.
- Overrun: event[i] while pending[i]=1 and pending[i] is not being cleared that cycle sets overrun[i]. Overrun is sticky until ovr_clr. If ovr_clr and a new overrun coincide, set wins.
- Mask: on mask_we, mask <= mask_wdata.
- Selection: the lowest index i with pending[i] & mask[i] wins.
- FSM:
  - IDLE: if any unmasked pending bit exists, latch the winner into irq_id and go to ASSERT.
  - ASSERT: irq_out=1. irq_id is frozen. Mask changes and new events do not withdraw the request. On irq_ack, clear pending[irq_id], reset the counter and go to HOLDOFF.
  - HOLDOFF: irq_out=0. Increment the counter. When counter==HOLDOFF-1, go to IDLE.
- irq_ack is ignored in IDLE and HOLDOFF.
- irq_id holds its last value outside ASSERT.
- irq_out is a registered state decode, glitch-free.

## Timing
- Source rise first sampled high at edge N:
  - pending[i]=1 after edge N.
  - If the source is enabled and the FSM is IDLE, irq_out=1 and irq_id valid after edge N+1 (2-cycle latency).
- Ack sampled at edge M: irq_out=0 and pending bit cleared after edge M.
- irq_out stays low for at least HOLDOFF+1 cycles after an ack.
- With a back-to-back pending source, irq_out re-asserts after edge M+HOLDOFF+1.
- Mask write at edge K affects selection from edge K+1.
- Reset asserted mid-ASSERT: irq_out drops immediately (asynchronous); all pending and overrun flags are lost.

## Test plan
- Reset: assert reset with irq_src=4'b1111 → all outputs 0. Release reset, sources stay high → no pending bit sets and irq_out stays 0.
- Single event: mask=4'b0001, 2-cycle pulse on irq_src[0] sampled at edge N → pending=0001 after N, irq_out=1/irq_id=0 after N+1. Ack at M → irq_out=0, pending=0000 after M, with no second interrupt.
- Priority: mask=1111, simultaneous rises on src1 and src3 → irq_id=1 first. Ack at M → irq_id=3 asserted after edge M+HOLDOFF+1 (M+5 with default HOLDOFF).
- Masked pending: mask=0000, pulse src2 → pending=0100, irq_out stays 0. Write mask=0100 at edge K → irq_out=1, irq_id=2 after edge K+1.
- Overrun: mask=0000, two separate pulses on src0 → overrun=0001, pending=0001. Pulse ovr_clr → overrun=0000.
- Ack collision: in ASSERT with irq_id=0, a new src0 rise sampled on the same edge as the ack → pending[0] remains 1, overrun[0] stays 0, and a second interrupt with irq_id=0 follows the hold-off. Reset pulse during ASSERT → irq_out=0 immediately, pending=0.
